alu_seq16: RTL and testbench
============================

Name: alu_seq16

Overview:
- Initiator-side sequencer for the 8-bit 6502-style ALU. It drives the ALU's op/AI/BI/CI/right/BCD/RDY inputs and consumes its registered OUT/CO/V/Z/N results.
- Executes multi-cycle 16-bit operations for the mathbox/vector math path: ADD16, SUB16, ASL16, and unsigned MUL8 (8x8 to 16).
- Sits between the math command issuer and one ALU instance; owns that ALU exclusively.

Parameters:
- MUL_ITER, 8, number of shift-add iterations for MUL8. Fixed to the operand width; do not override.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  clock enable; shared with the ALU; all state advances only when high
- start  in  1  command strobe; sampled in IDLE only
- cmd  in  2  00 ADD16, 01 SUB16, 10 MUL8, 11 ASL16
- opa  in  16  operand A; MUL8 uses opa[7:0] as multiplicand
- opb  in  16  operand B; MUL8 uses opb[7:0] as multiplier; ignored by ASL16
- busy  out  1  high from the start-accept edge until done
- done  out  1  one enabled-cycle pulse; result/flags valid while high and held afterwards
- result  out  16  operation result
- flag_c, flag_z, flag_n, flag_v  out  1 each  result flags
- alu_op  out  4  to ALU op
- alu_ai, alu_bi  out  8 each  to ALU AI/BI
- alu_ci, alu_right, alu_bcd, alu_rdy  out  1 each  to ALU; alu_right=0, alu_bcd=0, alu_rdy=1 constant
- alu_out  in  8  from ALU OUT (registered, valid one enabled cycle after issue)
- alu_co, alu_z, alu_n, alu_v  in  1 each  from ALU flags

Behaviour:
- Reset values: busy=0, done=0, result=0, all flags=0, state=IDLE.
- Idle ALU drive: op=1111, ai=bi=0, ci=0.
- ALU inputs are combinational from state and registered operands. The ALU latches them at the end of the enabled cycle, and alu_out/alu_co reflect them in the next enabled cycle.
- clk_en=0 freezes the FSM, all registers and done. A done pulse spans exactly one clk_en=1 cycle.

FSM states: IDLE, LO, HI, WB, M_ADD, M_SH, FIN.

- IDLE: on start & clk_en, latch cmd/opa/opb, set busy, clear acc.
  - ADD/SUB/ASL go to LO.
  - MUL goes to M_ADD with iteration counter=0.
- LO: drive the low byte.
  - ADD: op 0011, ai=opa[7:0], bi=opb[7:0], ci=0.
  - SUB: op 0111, same operands, ci=1.
  - ASL: op 1011, ai=opa[7:0], ci=0.
  - Next state HI.
- HI: drive the high byte with the same op, using opa/opb[15:8], ci=alu_co. Capture res_lo=alu_out and zlo=alu_z. Next state WB.
- WB: set result={alu_out,res_lo}, flag_c=alu_co, flag_n=alu_n, flag_v=alu_v, flag_z=zlo&alu_z. Next state FIN.
- M_ADD: drive op 0011, ai=acc_hi, bi=(mplr[0] ? mcand : 0), ci=0. Next state M_SH.
- M_SH: {acc_hi,acc_lo,mplr} shifted right by 1 with alu_co entering bit 15. Concretely acc={alu_co,alu_out,acc_lo[7:1]}, and the multiplier register shifts right. Increment the counter.
  - If counter reaches MUL_ITER-1 (i.e. 8 iterations done), go to FIN with result=acc, flag_c=0, flag_v=0, flag_n=acc[15], flag_z=(acc==0).
  - Otherwise go to M_ADD.
- FIN: done=1, busy=0, next state IDLE. start in FIN is ignored; it is accepted only in IDLE.
- Latency, counted from the start-accept edge to the done-high cycle, in enabled cycles:
  - ADD/SUB/ASL: done high in the 4th enabled cycle.
  - MUL8: done high in the 17th enabled cycle.
- start while busy is ignored with no queueing. New operands are accepted in the enabled cycle after done.
- SUB follows 6502 convention: flag_c=1 means no borrow.
- Reset mid-operation returns to IDLE on that edge: busy=0, done not pulsed, result and flags cleared.

Test Plan:
- ADD16 0x12F0+0x0120 -> result 0x1410, c=0, z=0, n=0, v=0; done exactly 4 enabled cycles after start; the HI cycle shows alu_ci=1.
- SUB16 0x1234-0x0235 -> 0x0FFF, c=1. SUB16 0x0001-0x0002 -> 0xFFFF, c=0, n=1. ADD16 0x7FFF+0x0001 -> 0x8000, v=1, n=1.
- ASL16 0x8001 -> 0x0002, c=1. ADD16 0xFFFF+0x0001 -> 0x0000, z=1, c=1 (z requires both bytes zero; 0x0100 gives z=0).
- MUL8 0xFF*0xFF -> 0xFE01; 0x00*0x5A -> 0x0000 with z=1; done exactly 17 enabled cycles after start; busy high throughout.
- clk_en toggling 1/0 every cycle during MUL8 0x0D*0x0B -> 0x008F, latency doubles in clocks; start pulsed while busy -> ignored, single done.
- reset asserted in M_SH of iteration 3 -> next cycle busy=0, result=0, no done; a subsequent ADD16 completes correctly.

Source files
------------

// File: rtl/alu_seq16.sv
// alu_seq16: drives one 8-bit 6502-style ALU through two-byte ADD16/SUB16/ASL16
// and an 8x8 unsigned shift-add MUL8, returning a 16-bit result with flags.
`timescale 1ns/1ps
module alu_seq16 #(
    parameter int MUL_ITER = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_right,
    output logic        alu_bcd,
    output logic        alu_rdy,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v
);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WB, S_M_ADD, S_M_SH, S_FIN} state_e;
    typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_SUB = 2'b01, CMD_MUL = 2'b10, CMD_ASL = 2'b11} cmd_e;

    localparam int               CNT_W     = $clog2(MUL_ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);
    localparam logic [3:0]       OP_ADD    = 4'b0011;
    localparam logic [3:0]       OP_SUB    = 4'b0111;
    localparam logic [3:0]       OP_ASL    = 4'b1011;
    localparam logic [3:0]       OP_IDLE   = 4'b1111;

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic [15:0]      opa_q, opa_d, opb_q, opb_d;
    logic [7:0]       mplr_q, mplr_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [7:0]       res_lo_q, res_lo_d;
    logic             zlo_q, zlo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [15:0]      result_q, result_d;
    logic             flag_c_q, flag_c_d, flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d, flag_v_q, flag_v_d;
    logic [3:0]       seq_op;

    always_comb begin
        case (cmd_q)
            CMD_SUB: seq_op = OP_SUB;
            CMD_ASL: seq_op = OP_ASL;
            default: seq_op = OP_ADD;
        endcase
    end

    // The ALU registers these, so each byte's result comes back one enabled cycle later.
    always_comb begin
        alu_op = OP_IDLE;
        alu_ai = 8'h00;
        alu_bi = 8'h00;
        alu_ci = 1'b0;
        case (state_q)
            S_LO: begin
                alu_op = seq_op;
                alu_ai = opa_q[7:0];
                alu_bi = (cmd_q == CMD_ASL) ? 8'h00 : opb_q[7:0];
                alu_ci = (cmd_q == CMD_SUB);
            end
            S_HI: begin
                alu_op = seq_op;
                alu_ai = opa_q[15:8];
                alu_bi = (cmd_q == CMD_ASL) ? 8'h00 : opb_q[15:8];
                alu_ci = alu_co;
            end
            S_M_ADD: begin
                alu_op = OP_ADD;
                alu_ai = acc_hi_q;
                alu_bi = mplr_q[0] ? opa_q[7:0] : 8'h00;
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every _d defaults to its _q (done_d to 0) first, so no branch can infer a latch.
        state_d  = state_q;
        cmd_d    = cmd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mplr_d   = mplr_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        res_lo_d = res_lo_q;
        zlo_d    = zlo_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d    = cmd_e'(cmd);
                    opa_d    = opa;
                    opb_d    = opb;
                    mplr_d   = opb[7:0];
                    acc_hi_d = 8'h00;
                    acc_lo_d = 8'h00;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = (cmd_e'(cmd) == CMD_MUL) ? S_M_ADD : S_LO;
                end
            end
            S_LO: state_d = S_HI;
            S_HI: begin
                res_lo_d = alu_out;
                zlo_d    = alu_z;
                state_d  = S_WB;
            end
            S_WB: begin
                result_d = {alu_out, res_lo_q};
                flag_c_d = alu_co;
                flag_z_d = zlo_q & alu_z;
                flag_n_d = alu_n;
                flag_v_d = alu_v;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_FIN;
            end
            S_M_ADD: state_d = S_M_SH;
            S_M_SH: begin
                // Partial-product sum enters the top; the 16-bit accumulator shifts right.
                acc_hi_d = {alu_co, alu_out[7:1]};
                acc_lo_d = {alu_out[0], acc_lo_q[7:1]};
                mplr_d   = {1'b0, mplr_q[7:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    result_d = {acc_hi_d, acc_lo_d};
                    flag_c_d = 1'b0;
                    flag_v_d = 1'b0;
                    flag_n_d = acc_hi_d[7];
                    flag_z_d = ({acc_hi_d, acc_lo_d} == 16'h0000);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_FIN;
                end else begin
                    state_d = S_M_ADD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= CMD_ADD;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            mplr_q   <= 8'h00;
            acc_hi_q <= 8'h00;
            acc_lo_q <= 8'h00;
            res_lo_q <= 8'h00;
            zlo_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mplr_q   <= mplr_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            res_lo_q <= res_lo_d;
            zlo_q    <= zlo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
    assign alu_right = 1'b0;
    assign alu_bcd   = 1'b0;
    assign alu_rdy   = 1'b1;

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: alu_seq16 wired to a behavioural 6502-style ALU; table vectors,
// hand-written corner sequences and random commands against an arithmetic reference.
`timescale 1ns/1ps
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        reset, clk_en, start;
    logic [1:0]  cmd;
    logic [15:0] opa, opb;
    logic        busy, done, flag_c, flag_z, flag_n, flag_v;
    logic [15:0] result;
    logic [3:0]  alu_op;
    logic [7:0]  alu_ai, alu_bi;
    logic        alu_ci, alu_right, alu_bcd, alu_rdy;
    logic [7:0]  alu_out = 8'h00;
    logic        alu_co = 1'b0, alu_z = 1'b0, alu_n = 1'b0, alu_v = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int en_edges = 0;

    always #5 clk = ~clk;

    alu_seq16 dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .cmd(cmd),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .alu_op(alu_op), .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
        .alu_right(alu_right), .alu_bcd(alu_bcd), .alu_rdy(alu_rdy),
        .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v)
    );

    // Behavioural 6502-style ALU: registered outputs, advances with clk_en & RDY.
    logic [7:0] alu_logic, alu_bi_eff;
    logic [8:0] alu_sum;
    always_comb begin
        case (alu_op[1:0])
            2'b00:   alu_logic = alu_ai | alu_bi;
            2'b01:   alu_logic = alu_ai & alu_bi;
            2'b10:   alu_logic = alu_ai ^ alu_bi;
            default: alu_logic = alu_ai;
        endcase
        case (alu_op[3:2])
            2'b00:   alu_bi_eff = alu_bi;
            2'b01:   alu_bi_eff = ~alu_bi;
            2'b10:   alu_bi_eff = alu_logic;
            default: alu_bi_eff = 8'h00;
        endcase
        alu_sum = {1'b0, alu_logic} + {1'b0, alu_bi_eff} + {8'h00, alu_ci};
    end
    always @(posedge clk) begin
        if (clk_en && alu_rdy) begin
            alu_out <= alu_sum[7:0];
            alu_co  <= alu_sum[8];
            alu_z   <= (alu_sum[7:0] == 8'h00);
            alu_n   <= alu_sum[7];
            alu_v   <= (alu_logic[7] == alu_bi_eff[7]) && (alu_sum[7] != alu_logic[7]);
        end
    end

    // Reference: {result, c, z, n, v} from 16-bit arithmetic semantics.
    function automatic logic [19:0] ref_model(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        fc, fv;
        case (c)
            2'b00: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[15:0];
                fc = s[16];
                fv = (a[15] == b[15]) && (r[15] != a[15]);
            end
            2'b01: begin
                r  = a - b;
                fc = (a >= b);
                fv = (a[15] != b[15]) && (r[15] != a[15]);
            end
            2'b10: begin
                r  = 16'(a[7:0]) * 16'(b[7:0]);
                fc = 1'b0;
                fv = 1'b0;
            end
            default: begin
                r  = {a[14:0], 1'b0};
                fc = a[15];
                fv = a[15] ^ a[14];
            end
        endcase
        return {r, fc, (r == 16'h0000), r[15], fv};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (clk_en) en_edges++;
        #1;
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                           input bit toggle, input bit poke,
                           output logic [15:0] res, output logic [3:0] flg, output int lat,
                           output int clocks, output bit busy_ok, output logic busy_at_done,
                           output logic hi_ci, output int done_en);
        int base;
        bit seen;
        clk_en = 1'b1; start = 1'b1; cmd = c; opa = a; opb = b;
        tick();
        start = 1'b0;
        base = en_edges; seen = 1'b0; lat = -1; clocks = 0; busy_ok = 1'b1;
        busy_at_done = 1'bx; hi_ci = 1'bx; res = 'x; flg = 'x; done_en = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                lat = en_edges - base + 1;
                res = result;
                flg = {flag_c, flag_z, flag_n, flag_v};
                busy_at_done = busy;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (i == 1) hi_ci = alu_ci;
                if (toggle) clk_en = ~clk_en;
                start = poke && (i == 4 || i == 5);
                if (poke) begin cmd = ~c; opa = ~a; opb = ~b; end
                tick();
                clocks++;
            end
        end
        start = 1'b0;
        if (seen) begin
            base = en_edges;
            for (int i = 0; i < 10 && done; i++) begin
                if (toggle) clk_en = ~clk_en;
                tick();
            end
            done_en = done ? -1 : en_edges - base;
        end
        clk_en = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  czn_v;
        int          lat;
    } vec_t;

    vec_t        vecs[12];
    logic [15:0] r_res;
    logic [3:0]  r_flg;
    int          r_lat, r_clk, r_den;
    bit          r_bok;
    logic        r_bdone, r_hci;
    logic [19:0] exp_v;
    int          cnt_done, cnt_busy;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        //           cmd    a         b         result    c z n v  latency
        vecs[0]  = '{2'b00, 16'h12F0, 16'h0120, 16'h1410, 4'b0000, 4};
        vecs[1]  = '{2'b01, 16'h1234, 16'h0235, 16'h0FFF, 4'b1000, 4};
        vecs[2]  = '{2'b01, 16'h0001, 16'h0002, 16'hFFFF, 4'b0010, 4};
        vecs[3]  = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 4};
        vecs[4]  = '{2'b11, 16'h8001, 16'hBEEF, 16'h0002, 4'b1001, 4};
        vecs[5]  = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 4};
        vecs[6]  = '{2'b00, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 4};
        vecs[7]  = '{2'b10, 16'hA5FF, 16'h3CFF, 16'hFE01, 4'b0010, 17};
        vecs[8]  = '{2'b10, 16'h1200, 16'h005A, 16'h0000, 4'b0100, 17};
        vecs[9]  = '{2'b10, 16'h000D, 16'h000B, 16'h008F, 4'b0000, 17};
        vecs[10] = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 4'b1001, 4};
        vecs[11] = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 4};

        reset = 1'b1; clk_en = 1'b1; start = 1'b0; cmd = 2'b00; opa = 16'h0; opb = 16'h0;
        tick(); tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        check("idle alu_op", alu_op, 4'hF);
        check("idle alu_ai/bi/ci", {alu_ai, alu_bi, alu_ci}, 0);
        check("alu constants", {alu_right, alu_bcd, alu_rdy}, 3'b001);
        reset = 1'b0;
        tick();
        check("idle busy", busy, 0);

        for (int k = 0; k < 12; k++) begin
            run_cmd(vecs[k].cmd, vecs[k].a, vecs[k].b, 1'b0, 1'b0,
                    r_res, r_flg, r_lat, r_clk, r_bok, r_bdone, r_hci, r_den);
            check($sformatf("v%0d result", k), r_res, vecs[k].res);
            check($sformatf("v%0d flags czn_v", k), r_flg, vecs[k].czn_v);
            check($sformatf("v%0d latency", k), r_lat, vecs[k].lat);
            check($sformatf("v%0d done width", k), r_den, 1);
            check($sformatf("v%0d busy until done", k), r_bok, 1);
            check($sformatf("v%0d busy at done", k), r_bdone, 0);
            if (k == 0) check("v0 HI alu_ci", r_hci, 1);
        end

        // MUL8 with clk_en toggling and start pulsed while busy.
        run_cmd(2'b10, 16'h000D, 16'h000B, 1'b1, 1'b1,
                r_res, r_flg, r_lat, r_clk, r_bok, r_bdone, r_hci, r_den);
        check("toggle result", r_res, 16'h008F);
        check("toggle flags", r_flg, 4'b0000);
        check("toggle enabled latency", r_lat, 17);
        check("toggle clock latency", r_clk, 32);
        check("toggle done width", r_den, 1);
        check("toggle busy until done", r_bok, 1);
        cnt_done = 0; cnt_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) cnt_done++;
            if (busy) cnt_busy++;
        end
        check("no queued done", cnt_done, 0);
        check("no queued busy", cnt_busy, 0);

        // Reset during M_SH of iteration 3 (8th enabled cycle after accept).
        clk_en = 1'b1; start = 1'b1; cmd = 2'b10; opa = 16'h00FF; opb = 16'h00FF;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("mid-op busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset busy", busy, 0);
        check("post-reset done", done, 0);
        check("post-reset result", result, 0);
        check("post-reset flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) cnt_done++;
        end
        check("post-reset no done", cnt_done, 0);
        run_cmd(2'b00, 16'h12F0, 16'h0120, 1'b0, 1'b0,
                r_res, r_flg, r_lat, r_clk, r_bok, r_bdone, r_hci, r_den);
        check("post-reset add result", r_res, 16'h1410);
        check("post-reset add flags", r_flg, 4'b0000);
        check("post-reset add latency", r_lat, 4);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  c;
            logic [15:0] a, b;
            c = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            exp_v = ref_model(c, a, b);
            run_cmd(c, a, b, 1'b0, 1'b0,
                    r_res, r_flg, r_lat, r_clk, r_bok, r_bdone, r_hci, r_den);
            check($sformatf("rnd%0d cmd%0d %h,%h result", k, c, a, b), r_res, exp_v[19:4]);
            check($sformatf("rnd%0d cmd%0d %h,%h flags", k, c, a, b), r_flg, exp_v[3:0]);
            check($sformatf("rnd%0d latency", k), r_lat, (c == 2'b10) ? 17 : 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
